// File: rtl/seven_seg_pkg.sv
// Shared types and segment code table for the seven-segment scan driver.
// Provides seg_t, SEG_BLANK, SEG_CODE[16] and hex_to_seg().
package seven_seg_pkg;

    // Active-low segments {g,f,e,d,c,b,a}; bit 0 is segment a.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t SEG_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic seg_t hex_to_seg(input logic [3:0] hex);
        return SEG_CODE[hex];
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Display-side bundle for seven_seg_scan_driver.
// master: drives en/load/value/dp_in/blank_mask; slave: drives seg/dp/an/frame_start/pending.
interface seven_seg_scan_driver_if
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    seg_t                    seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_start;
    logic                    pending;

    modport master (
        output en, load, value, dp_in, blank_mask,
        input  seg, dp, an, frame_start, pending
    );

    modport slave (
        input  en, load, value, dp_in, blank_mask,
        output seg, dp, an, frame_start, pending
    );

endinterface

// File: rtl/seven_seg_scan_driver_seg_hex_lut.sv
// Combinational hex digit to active-low segment pattern lookup.
// Ports: hex (4-bit digit in), seg (seg_t pattern out).
module seg_hex_lut
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous double buffering.
// Ports: clk, rst (async high), bus (slave modport). Optional macro: SEVEN_SEG_LZS_EN (leading-zero suppression).
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    seven_seg_scan_driver_if.slave bus
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      tick_cnt;
    logic [IDX_W-1:0]      idx;
    logic [VAL_W-1:0]      stage_val;
    logic [VAL_W-1:0]      disp_val;
    logic [NUM_DIGITS-1:0] stage_dp;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic                  pending_q;
    logic                  frame_start_q;
    seg_t                  seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;

    logic       advance;
    logic       frame_wrap;
    logic       apply;
    logic [3:0] cur_hex;
    seg_t       lut_seg;
    logic       cur_blank;
    logic       lzs_blank;

    assign advance    = bus.en && (tick_cnt == TICK_LAST);
    assign frame_wrap = advance && (idx == IDX_LAST);
    assign apply      = frame_wrap && pending_q;

    // Refresh counter and digit index; both freeze while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            idx      <= '0;
        end else if (bus.en) begin
            if (advance) begin
                tick_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // Staging/display double buffer. A load coinciding with the
    // wrap moves the old staging out and keeps the new one pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_val     <= '0;
            stage_dp      <= '0;
            disp_val      <= '0;
            disp_dp       <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            if (bus.load) begin
                stage_val <= bus.value;
                stage_dp  <= bus.dp_in;
            end
            if (apply) begin
                disp_val <= stage_val;
                disp_dp  <= stage_dp;
            end
            frame_start_q <= apply;
            if (bus.load) begin
                pending_q <= 1'b1;
            end else if (frame_wrap) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign cur_hex   = disp_val[4*idx +: 4];
    assign cur_blank = bus.blank_mask[idx];

    seg_hex_lut u_lut (
        .hex (cur_hex),
        .seg (lut_seg)
    );

`ifdef SEVEN_SEG_LZS_EN
    // Dark when this digit and all higher ones are zero; digit 0 always shown.
    assign lzs_blank = (idx != '0) && ((disp_val >> (4*idx)) == '0);
`else
    assign lzs_blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else if (!bus.en) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= ~(NUM_DIGITS'(1) << idx);
            seg_q <= (cur_blank || lzs_blank) ? SEG_BLANK : lut_seg;
            dp_q  <= cur_blank ? 1'b1 : ~disp_dp[idx];
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;
    assign bus.frame_start = frame_start_q;
    assign bus.pending     = pending_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4).
// Table vectors, directed corner sequences and random stimulus against a position-based model.
module tb_seven_seg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic clk = 1'b0;
    logic rst = 1'b0;

    seven_seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pos = number of enabled cycles since reset.
    int         pos;
    logic [3:0] m_disp  [N];
    logic [3:0] m_stage [N];
    logic [N-1:0] m_dp;
    logic [N-1:0] m_sdp;
    bit         m_pend;

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dpi;
        logic [3:0]      blk;
        logic [3:0][6:0] s;
        logic [3:0]      dpo;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [6:0] ref_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [13:0] act();
        return {bus.an, bus.seg, bus.dp, bus.frame_start, bus.pending};
    endfunction

    task automatic check(input string name, input logic [31:0] a,
                         input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
        end
    endtask

    task automatic model_reset();
        pos = 0;
        for (int j = 0; j < N; j++) begin
            m_disp[j]  = 4'h0;
            m_stage[j] = 4'h0;
        end
        m_dp   = '0;
        m_sdp  = '0;
        m_pend = 1'b0;
    endtask

    // One clock: predict from current inputs, advance, compare.
    task automatic step();
        logic [13:0] e;
        logic [3:0]  an_e;
        logic [6:0]  s;
        logic        p;
        bit          wrap;
        bit          lz;
        int          d;
        wrap = bus.en && (pos % FRAME == FRAME - 1);
        d    = (pos / DIV) % N;
        lz   = 1'b0;
        if (!bus.en) begin
            an_e = 4'hF;
            s    = 7'h7F;
            p    = 1'b1;
        end else begin
            an_e = ~(4'b0001 << d);
`ifdef SEVEN_SEG_LZS_EN
            if (d > 0) begin
                lz = 1'b1;
                for (int j = d; j < N; j++)
                    if (m_disp[j] != 4'h0) lz = 1'b0;
            end
`endif
            if (bus.blank_mask[d]) begin
                s = 7'h7F;
                p = 1'b1;
            end else begin
                s = lz ? 7'h7F : ref_seg(m_disp[d]);
                p = ~m_dp[d];
            end
        end
        e = {an_e, s, p, wrap && m_pend, bus.load || (m_pend && !wrap)};
        if (wrap && m_pend) begin
            m_disp = m_stage;
            m_dp   = m_sdp;
        end
        if (bus.load) begin
            for (int j = 0; j < N; j++) m_stage[j] = bus.value[4*j +: 4];
            m_sdp = bus.dp_in;
        end
        m_pend = bus.load || (m_pend && !wrap);
        if (bus.en) pos++;
        @(posedge clk);
        #1;
        check("model", 32'(act()), 32'(e));
    endtask

    task automatic wait_fs(input string name);
        int k;
        k = 0;
        while (!bus.frame_start && k < FRAME + 2) begin
            step();
            k++;
        end
        check(name, 32'(bus.frame_start), 32'd1);
    endtask

    task automatic show_frame(input int v);
        int d;
        for (int k = 0; k < FRAME; k++) begin
            step();
            d = k / DIV;
            check("tbl_an", 32'(bus.an), 32'(4'(~(4'b0001 << d))));
            check("tbl_seg", 32'(bus.seg), 32'(vecs[v].s[d]));
            check("tbl_dp", 32'(bus.dp), 32'(vecs[v].dpo[d]));
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'h0, 4'h0,
                    {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
        vecs[1] = '{16'h89AB, 4'h0, 4'h0,
                    {7'h00, 7'h10, 7'h08, 7'h03}, 4'hF};
        vecs[2] = '{16'hCDEF, 4'h0, 4'h0,
                    {7'h46, 7'h21, 7'h06, 7'h0E}, 4'hF};
        vecs[3] = '{16'h5670, 4'b0001, 4'b0100,
                    {7'h12, 7'h7F, 7'h78, 7'h40}, 4'b1110};
        vecs[4] = '{16'hF0F0, 4'b1010, 4'h0,
                    {7'h0E, 7'h40, 7'h0E, 7'h40}, 4'b0101};
        vecs[5] = '{16'h6060, 4'h0, 4'h0,
                    {7'h02, 7'h40, 7'h02, 7'h40}, 4'hF};
`ifdef SEVEN_SEG_LZS_EN
        vecs[6] = '{16'h0070, 4'h0, 4'h0,
                    {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'hF};
`else
        vecs[6] = '{16'h0070, 4'h0, 4'h0,
                    {7'h40, 7'h40, 7'h78, 7'h40}, 4'hF};
`endif

        bus.en         = 1'b0;
        bus.load       = 1'b0;
        bus.value      = '0;
        bus.dp_in      = '0;
        bus.blank_mask = '0;
        model_reset();

        #1 rst = 1'b1;
        #2;
        check("reset_state", 32'(act()), 32'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}));

        @(negedge clk);
        rst    = 1'b0;
        bus.en = 1'b1;
        step();
        check("first_digit", 32'({bus.an, bus.seg}), 32'({4'b1110, 7'h40}));

        // Table: load, wait for the swap, inspect the next full frame.
        for (int i = 0; i < 7; i++) begin
            bus.blank_mask = vecs[i].blk;
            bus.value      = vecs[i].val;
            bus.dp_in      = vecs[i].dpi;
            bus.load       = 1'b1;
            step();
            bus.load = 1'b0;
            check("pending_rise", 32'(bus.pending), 32'd1);
            wait_fs("frame_start");
            show_frame(i);
        end
        bus.blank_mask = '0;
        bus.dp_in      = '0;

        // Load colliding with the frame wrap.
        bus.value = 16'hABCD;
        bus.load  = 1'b1;
        step();
        bus.load = 1'b0;
        while (pos % FRAME != FRAME - 1) step();
        bus.value = 16'h00EF;
        bus.load  = 1'b1;
        step();
        bus.load = 1'b0;
        check("collide_pending", 32'(bus.pending), 32'd1);
        check("collide_fs", 32'(bus.frame_start), 32'd1);
        step();
        check("collide_abcd_d0", 32'(bus.seg), 32'(7'h21));
        wait_fs("collide_fs2");
        check("collide_pend_clr", 32'(bus.pending), 32'd0);
        step();
        check("ef_d0", 32'(bus.seg), 32'(7'h0E));
        repeat (8) step();
`ifdef SEVEN_SEG_LZS_EN
        check("ef_d2", 32'(bus.seg), 32'(7'h7F));
`else
        check("ef_d2", 32'(bus.seg), 32'(7'h40));
`endif

        // Enable hold mid-digit.
        while (pos % DIV != 1) step();
        bus.en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("en_hold_an", 32'(bus.an), 32'hF);
        end
        bus.en = 1'b1;
        repeat (DIV + 2) step();

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            bus.en         = ($urandom_range(0, 9) != 0);
            bus.load       = ($urandom_range(0, 19) == 0);
            bus.value      = 16'($urandom);
            bus.dp_in      = 4'($urandom);
            bus.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step();
        end

        // Asynchronous reset mid-frame with data pending.
        bus.en         = 1'b1;
        bus.blank_mask = '0;
        bus.value      = 16'h9999;
        bus.load       = 1'b1;
        step();
        bus.load = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        check("async_reset", 32'(act()), 32'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        check("restart_digit", 32'({bus.an, bus.seg}), 32'({4'b1110, 7'h40}));
        repeat (FRAME + 3) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
